// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer states and 8N1 line levels.
// Intended to be reused by the receive/loader path as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uartState_t;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        UART_START_LVL = 1'b0;
    localparam logic        UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_result_tx_if.sv
// Writeback result bus: the done strobe plus the 16-bit result it qualifies.
interface uart_result_tx_if;

    logic        done;
    logic [15:0] ResultW;

    modport master (output done, output ResultW);
    modport slave  (input  done, input  ResultW);

endinterface

// File: rtl/uart_result_tx_fifo.sv
// Result word FIFO: synchronous circular buffer with combinational head read.
// A push while full is accepted only when a pop happens on the same edge.
module result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_CNT  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      countQ;
    logic             doPush;
    logic             doPop;

    assign empty  = (countQ == '0);
    assign full   = (countQ == FULL_CNT);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr];
    assign count  = countQ;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + ONE_CNT;
                2'b01:   countQ <= countQ - ONE_CNT;
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/uart_result_tx.sv
// Streams writeback results to the host as UART 8N1, two bytes per word,
// high byte first. Words are buffered in a small FIFO; drops are flagged.
module uart_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_result_tx_if.slave              res,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    import uart_pkg::*;

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uartState_t state, stateNext;
    logic [CW-1:0] baudCnt, baudNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [7:0]    shiftReg, shiftNext;
    logic [7:0]    holdLow, holdLowNext;
    logic          sendHigh, sendHighNext;
    logic          txReg, txNext;
    logic          overflowReg;

    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [15:0]   fifoDout;
    logic          bitDone;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) uFifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (res.done),
        .pop   (fifoPop),
        .din   (res.ResultW),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifo_count)
    );

    assign bitDone  = (baudCnt == BAUD_LAST);
    assign tx       = txReg;
    assign busy     = (state != IDLE) || !fifoEmpty;
    assign overflow = overflowReg;

    // Serializer state and datapath registers; tx is registered to stay glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            holdLow  <= '0;
            sendHigh <= 1'b1;
            txReg    <= UART_STOP_LVL;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            holdLow  <= holdLowNext;
            sendHigh <= sendHighNext;
            txReg    <= txNext;
        end
    end

    // Next-state logic; tx is derived from the next state so it changes with the state.
    // Only the low byte of a popped word must outlive the pop, so only it is held.
    always_comb begin
        stateNext    = state;
        baudNext     = baudCnt;
        bitIdxNext   = bitIdx;
        shiftNext    = shiftReg;
        holdLowNext  = holdLow;
        sendHighNext = sendHigh;
        fifoPop      = 1'b0;
        txNext       = UART_STOP_LVL;

        case (state)
            IDLE: begin
                baudNext = '0;
                if (!fifoEmpty) begin
                    fifoPop      = 1'b1;
                    holdLowNext  = fifoDout[7:0];
                    shiftNext    = fifoDout[15:8];
                    sendHighNext = 1'b1;
                    stateNext    = START;
                end
            end
            START: begin
                if (bitDone) begin
                    baudNext   = '0;
                    bitIdxNext = '0;
                    stateNext  = DATA;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            DATA: begin
                if (bitDone) begin
                    baudNext  = '0;
                    shiftNext = shiftReg >> 1;
                    if (bitIdx == LAST_BIT) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 1'b1;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            STOP: begin
                if (bitDone) begin
                    baudNext = '0;
                    if (sendHigh) begin
                        shiftNext    = holdLow;
                        sendHighNext = 1'b0;
                        stateNext    = START;
                    end else if (!fifoEmpty) begin
                        fifoPop      = 1'b1;
                        holdLowNext  = fifoDout[7:0];
                        shiftNext    = fifoDout[15:8];
                        sendHighNext = 1'b1;
                        stateNext    = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        case (stateNext)
            START:   txNext = UART_START_LVL;
            DATA:    txNext = shiftNext[0];
            default: txNext = UART_STOP_LVL;
        endcase
    end

    // Sticky drop flag: a word arrives while full and nothing leaves this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflowReg <= 1'b0;
        end else if (res.done && fifoFull && !fifoPop) begin
            overflowReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Scoreboard bench for uart_result_tx: stimulus queues expected bytes,
// a line monitor decodes tx frames and checks them against the queue.
module tb_uart_result_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifoCount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] expQ[$];
    int         startQ[$];

    uart_result_tx_if res();

    uart_result_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .res        (res),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifoCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset       = 1'b0;
        res.done    = 1'b0;
        res.ResultW = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pushWord(input logic [15:0] w);
        expQ.push_back(w[15:8]);
        expQ.push_back(w[7:0]);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain queue", expQ.size(), 0);
        check("drain busy", busy, 0);
    endtask

    // Line monitor: finds a start bit, samples each bit mid-cell, scores the byte.
    initial begin : monitor
        logic [7:0] rx;
        logic       stopBit;
        logic       aborted;
        int         t0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                t0      = cyc;
                aborted = 1'b0;
                rx      = '0;
                stopBit = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    repeat ((b == 0) ? 2 : 4) @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (b == 0)      check("start bit", tx, 0);
                    else if (b < 9)  rx[b-1] = tx;
                    else             stopBit = tx;
                end
                if (!aborted) begin
                    startQ.push_back(t0);
                    if (expQ.size() == 0) begin
                        check("unexpected byte", rx, 32'hFFFF_FFFF);
                    end else begin
                        check("rx byte", rx, expQ.pop_front());
                    end
                    check("stop bit", stopBit, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int unsigned seq[20] = '{0,1,0,1,0,0,1,0,1,1, 0,0,1,0,1,1,0,1,0,1};
        int unsigned ovCnt[6] = '{1,1,2,3,4,4};
        int unsigned ovFlag[6] = '{0,0,0,0,0,1};
        int bad;

        // Reset values while reset is held
        reset       = 1'b1;
        res.done    = 1'b0;
        res.ResultW = '0;
        #1 reset = 1'b0;
        #3;
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        check("reset count", fifoCount, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Idle line for 1000 cycles
        bad = 0;
        repeat (1000) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle violations", bad, 0);

        // Single word 0xA55A, bit-exact waveform
        pushWord(16'hA55A);
        res.done = 1'b1; res.ResultW = 16'hA55A;
        tick();
        res.done = 1'b0;
        check("sw count after push", fifoCount, 1);
        check("sw busy after push", busy, 1);
        check("sw tx before pop", tx, 1);
        tick();
        check("sw count after pop", fifoCount, 0);
        for (int c = 0; c < 80; c++) begin
            check("sw bit", tx, seq[c / 4]);
            tick();
        end
        check("sw tx after word", tx, 1);
        check("sw busy after word", busy, 0);
        waitDrain(100);

        // Back-to-back words, frames must abut
        startQ.delete();
        pushWord(16'h0001);
        pushWord(16'h8000);
        res.done = 1'b1; res.ResultW = 16'h0001;
        tick();
        res.done = 1'b0;
        repeat (9) tick();
        res.done = 1'b1; res.ResultW = 16'h8000;
        tick();
        res.done = 1'b0;
        waitDrain(400);
        check("b2b frames", startQ.size(), 4);
        if (startQ.size() >= 4) begin
            for (int i = 0; i < 3; i++) check("b2b gap", startQ[i+1] - startQ[i], 10 * CPB);
        end

        // Overflow: six back-to-back pushes into a depth-4 FIFO
        doReset();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) pushWord(16'(i + 1));
            res.done = 1'b1; res.ResultW = 16'(i + 1);
            tick();
            check("ov count", fifoCount, ovCnt[i]);
            check("ov flag", overflow, ovFlag[i]);
        end
        res.done = 1'b0;
        waitDrain(600);
        check("ov sticky", overflow, 1);

        // Push while full on the exact edge a pop happens
        doReset();
        for (int i = 1; i <= 5; i++) begin
            pushWord(16'h1000 + 16'(i));
            res.done = 1'b1; res.ResultW = 16'h1000 + 16'(i);
            tick();
        end
        res.done = 1'b0;
        check("fp count filled", fifoCount, 4);
        repeat (76) tick();
        check("fp count before", fifoCount, 4);
        pushWord(16'hBEEF);
        res.done = 1'b1; res.ResultW = 16'hBEEF;
        tick();
        res.done = 1'b0;
        check("fp count after", fifoCount, 4);
        check("fp overflow", overflow, 0);
        waitDrain(800);
        check("fp overflow end", overflow, 0);

        // Reset in the middle of data bit 3 of 0xFFFF
        res.done = 1'b1; res.ResultW = 16'hFFFF;
        tick();
        res.done = 1'b0;
        tick();
        repeat (17) tick();
        check("mr busy before", busy, 1);
        reset = 1'b0;
        #1;
        check("mr tx", tx, 1);
        check("mr busy", busy, 0);
        check("mr count", fifoCount, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("mr tx released", tx, 1);
        pushWord(16'h1234);
        res.done = 1'b1; res.ResultW = 16'h1234;
        tick();
        res.done = 1'b0;
        waitDrain(300);

        check("final queue", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
